ctr_word_packer: RTL and testbench

Upstream feeder for the AES-CTR datapath. Accepts a 32-bit word stream with byte keep and end-of-message marking, and assembles it into 128-bit blocks. Each block is presented with a byte mask and a last flag on a valid/ready interface that drives the CTR core's data input. Partial final blocks are padded, and a sync flush discards in-flight data when a new key or IV is loaded.

---
 rtl/ctr_word_packer_if.sv | 28 ++
 rtl/ctr_word_packer.sv | 161 ++++++++++++++++
 tb/tb_ctr_word_packer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ctr_word_packer_if.sv
// Stream bundle for ctr_word_packer: 32-bit word input side and 128-bit block output side.
// The slave modport is the packer's view; the master modport is the feeder/consumer view.
interface ctr_word_packer_if;
  logic [31:0]  s_data_i;
  logic [3:0]   s_keep_i;
  logic         s_last_i;
  logic         s_valid_i;
  logic         s_ready_o;
  logic [127:0] m_block_o;
  logic [15:0]  m_mask_o;
  logic         m_last_o;
  logic         m_valid_o;
  logic         m_ready_i;

  modport slave (
    input  s_data_i, s_keep_i, s_last_i, s_valid_i,
    output s_ready_o,
    output m_block_o, m_mask_o, m_last_o, m_valid_o,
    input  m_ready_i
  );

  modport master (
    output s_data_i, s_keep_i, s_last_i, s_valid_i,
    input  s_ready_o,
    input  m_block_o, m_mask_o, m_last_o, m_valid_o,
    output m_ready_i
  );
endinterface

// File: rtl/ctr_word_packer.sv
// Packs a 32-bit keep/last word stream into padded 128-bit blocks for the AES-CTR core.
// Optional macro PACKER_KEEP_CHECK_EN: flags illegal keep patterns on err_o and packs keep as given.
module ctr_word_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  ctr_word_packer_if.slave        bus,
  output logic [31:0]             blk_cnt_o,
  output logic                    err_o
);

  logic [1:0]   r_cnt;
  logic [31:0]  r_asm_lane [4];
  logic [3:0]   r_asm_nib  [4];
  logic [127:0] r_m_block;
  logic [15:0]  r_m_mask;
  logic         r_m_last;
  logic         r_m_valid;
  logic [31:0]  r_blk_cnt;
  logic         r_err;

  logic         w_s_ready;
  logic         w_accept;
  logic         w_close;
  logic         w_out_xfer;
  logic         w_keep_err;
  logic [3:0]   w_keep;
  logic [31:0]  w_word;
  logic [31:0]  w_lane [4];
  logic [3:0]   w_nib  [4];

  // Bytes not covered by keep are replaced by the pad value.
  function automatic logic [31:0] pad_word(input logic [31:0] data, input logic [3:0] keep);
    pad_word = {keep[3] ? data[31:24] : PAD_BYTE,
                keep[2] ? data[23:16] : PAD_BYTE,
                keep[1] ? data[15:8]  : PAD_BYTE,
                keep[0] ? data[7:0]   : PAD_BYTE};
  endfunction

`ifdef PACKER_KEEP_CHECK_EN
  function automatic logic keep_violation(input logic [3:0] keep, input logic last);
    logic bad;
    if (!last) begin
      bad = (keep != 4'hF);
    end else begin
      case (keep)
        4'hF, 4'hE, 4'hC, 4'h8, 4'h0: bad = 1'b0;
        default:                      bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  assign w_keep_err = keep_violation(bus.s_keep_i, bus.s_last_i);
`else
  assign w_keep_err = 1'b0;
`endif

  assign w_s_ready  = !flush_i && (!r_m_valid || bus.m_ready_i);
  assign w_accept   = bus.s_valid_i && w_s_ready;
  assign w_close    = (r_cnt == 2'd3) || bus.s_last_i;
  assign w_out_xfer = r_m_valid && bus.m_ready_i;

  // Effective keep: only the closing word of a message may be partial unless checking is on.
  always_comb begin
    w_keep = 4'hF;
`ifdef PACKER_KEEP_CHECK_EN
    w_keep = bus.s_keep_i;
`else
    if (bus.s_last_i) begin
      w_keep = bus.s_keep_i;
    end else begin
      w_keep = 4'hF;
    end
`endif
  end

  // Candidate block: stored lanes below cnt, current word at cnt, pad above.
  always_comb begin
    w_word = pad_word(bus.s_data_i, w_keep);
    for (int i = 0; i < 4; i++) begin
      w_lane[i] = {4{PAD_BYTE}};
      w_nib[i]  = 4'h0;
      if (2'(i) < r_cnt) begin
        w_lane[i] = r_asm_lane[i];
        w_nib[i]  = r_asm_nib[i];
      end else if (2'(i) == r_cnt) begin
        w_lane[i] = w_word;
        w_nib[i]  = w_keep;
      end else begin
        w_lane[i] = {4{PAD_BYTE}};
        w_nib[i]  = 4'h0;
      end
    end
  end

  // Assembly and output registers; flush outranks both handshakes in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 2'd0;
      r_m_block <= 128'h0;
      r_m_mask  <= 16'h0;
      r_m_last  <= 1'b0;
      r_m_valid <= 1'b0;
      r_blk_cnt <= 32'd0;
      r_err     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_asm_lane[i] <= 32'h0;
        r_asm_nib[i]  <= 4'h0;
      end
    end else if (flush_i) begin
      r_cnt     <= 2'd0;
      r_m_valid <= 1'b0;
      r_blk_cnt <= 32'd0;
      for (int i = 0; i < 4; i++) begin
        r_asm_lane[i] <= 32'h0;
        r_asm_nib[i]  <= 4'h0;
      end
    end else begin
      if (w_out_xfer) begin
        r_blk_cnt <= r_blk_cnt + 32'd1;
      end
      if (w_accept && w_keep_err) begin
        r_err <= 1'b1;
      end
      if (w_accept && w_close) begin
        r_cnt     <= 2'd0;
        r_m_block <= {w_lane[0], w_lane[1], w_lane[2], w_lane[3]};
        r_m_mask  <= {w_nib[0], w_nib[1], w_nib[2], w_nib[3]};
        r_m_last  <= bus.s_last_i;
        r_m_valid <= 1'b1;
        for (int i = 0; i < 4; i++) begin
          r_asm_lane[i] <= 32'h0;
          r_asm_nib[i]  <= 4'h0;
        end
      end else begin
        if (w_out_xfer) begin
          r_m_valid <= 1'b0;
        end
        if (w_accept) begin
          r_cnt <= r_cnt + 2'd1;
          for (int i = 0; i < 4; i++) begin
            r_asm_lane[i] <= w_lane[i];
            r_asm_nib[i]  <= w_nib[i];
          end
        end
      end
    end
  end

  assign bus.s_ready_o = w_s_ready;
  assign bus.m_block_o = r_m_block;
  assign bus.m_mask_o  = r_m_mask;
  assign bus.m_last_o  = r_m_last;
  assign bus.m_valid_o = r_m_valid;
  assign blk_cnt_o     = r_blk_cnt;
  assign err_o         = r_err;

endmodule

// File: tb/tb_ctr_word_packer.sv
// Self-checking bench for ctr_word_packer: directed scenarios plus randomized traffic
// compared every cycle against a byte-queue reference model.
module tb_ctr_word_packer;
  localparam logic [7:0] PAD = 8'h5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic [31:0] blk_cnt_o;
  logic        err_o;

  ctr_word_packer_if u_if();

  ctr_word_packer #(.PAD_BYTE(PAD)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .bus       (u_if),
    .blk_cnt_o (blk_cnt_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bytes of the block being assembled, plus the expected output register.
  logic [7:0]   q_data [$];
  bit           q_mask [$];
  logic [127:0] exp_block = '0;
  logic [15:0]  exp_mask  = '0;
  bit           exp_last  = 1'b0;
  bit           exp_valid = 1'b0;
  logic [31:0]  exp_cnt   = '0;
  bit           exp_err   = 1'b0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit keep_bad(input logic [3:0] k, input bit l);
    if (!l) return (k != 4'hF);
    return !(k inside {4'hF, 4'hE, 4'hC, 4'h8, 4'h0});
  endfunction

  function automatic logic [31:0] word_of(input int j);
    return {8'(17 * (4 * j)), 8'(17 * (4 * j + 1)), 8'(17 * (4 * j + 2)), 8'(17 * (4 * j + 3))};
  endfunction

  task automatic model_clear();
    q_data.delete();
    q_mask.delete();
    exp_valid = 1'b0;
    exp_cnt   = '0;
  endtask

  // Drive one cycle at the negedge, check outputs, advance the model, move to the next negedge.
  task automatic step(input bit v, input logic [31:0] d, input logic [3:0] k, input bit l,
                      input bit rdy, input bit fl);
    bit exp_ready, acc, xfer;
    logic [3:0] ek;
    u_if.s_valid_i = v;
    u_if.s_data_i  = d;
    u_if.s_keep_i  = k;
    u_if.s_last_i  = l;
    u_if.m_ready_i = rdy;
    flush_i        = fl;
    #1;
    exp_ready = !fl && (!exp_valid || rdy);
    check_val("s_ready", u_if.s_ready_o, exp_ready);
    check_val("m_valid", u_if.m_valid_o, exp_valid);
    check_val("blk_cnt", blk_cnt_o, exp_cnt);
    check_val("err", err_o, exp_err);
    if (exp_valid) begin
      check_val("m_block", u_if.m_block_o, exp_block);
      check_val("m_mask", u_if.m_mask_o, exp_mask);
      check_val("m_last", u_if.m_last_o, exp_last);
    end
    acc  = v && exp_ready;
    xfer = exp_valid && rdy;
    if (fl) begin
      model_clear();
    end else begin
      if (xfer) begin
        exp_cnt++;
        exp_valid = 1'b0;
      end
      if (acc) begin
`ifdef PACKER_KEEP_CHECK_EN
        ek = k;
        if (keep_bad(k, l)) exp_err = 1'b1;
`else
        ek = l ? k : 4'hF;
`endif
        for (int b = 0; b < 4; b++) begin
          q_data.push_back(ek[3 - b] ? 8'(d >> (24 - 8 * b)) : PAD);
          q_mask.push_back(ek[3 - b]);
        end
        if (l || q_data.size() == 16) begin
          while (q_data.size() < 16) begin
            q_data.push_back(PAD);
            q_mask.push_back(1'b0);
          end
          for (int i = 0; i < 16; i++) begin
            exp_block = {exp_block[119:0], q_data[i]};
            exp_mask  = {exp_mask[14:0], q_mask[i]};
          end
          exp_last  = l;
          exp_valid = 1'b1;
          q_data.delete();
          q_mask.delete();
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 32'h0, 4'h0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    logic [31:0] w [4];
    logic [31:0] d5;
    logic [3:0]  last_keeps [5];
    last_keeps[0] = 4'hF; last_keeps[1] = 4'hE; last_keeps[2] = 4'hC;
    last_keeps[3] = 4'h8; last_keeps[4] = 4'h0;

    rst_n = 1'b0;
    flush_i = 1'b0;
    u_if.s_valid_i = 1'b0; u_if.s_data_i = '0; u_if.s_keep_i = '0;
    u_if.s_last_i = 1'b0;  u_if.m_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_s_ready", u_if.s_ready_o, 1'b1);
    check_val("rst_m_block", u_if.m_block_o, 128'h0);
    check_val("rst_m_mask", u_if.m_mask_o, 16'h0);
    check_val("rst_m_last", u_if.m_last_o, 1'b0);
    check_val("rst_m_valid", u_if.m_valid_o, 1'b0);
    check_val("rst_blk_cnt", blk_cnt_o, 32'd0);
    check_val("rst_err", err_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full two-block message with the sink always ready.
    for (int j = 0; j < 8; j++) begin
      step(1'b1, word_of(j), 4'hF, (j == 7), 1'b1, 1'b0);
      if (j == 3) begin
        check_val("tp_blk1", u_if.m_block_o, 128'h00112233_44556677_8899aabb_ccddeeff);
        check_val("tp_mask1", u_if.m_mask_o, 16'hFFFF);
        check_val("tp_last1", u_if.m_last_o, 1'b0);
      end
    end
    check_val("tp_mask2", u_if.m_mask_o, 16'hFFFF);
    check_val("tp_last2", u_if.m_last_o, 1'b1);
    idle(1'b1);
    check_val("tp_cnt2", blk_cnt_o, 32'd2);

    // Partial final block: fifth word keeps only its top two bytes.
    for (int j = 0; j < 4; j++) step(1'b1, $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
    d5 = $urandom;
    step(1'b1, d5, 4'hC, 1'b1, 1'b1, 1'b0);
    check_val("tp_part_blk", u_if.m_block_o, {d5[31:16], {14{PAD}}});
    check_val("tp_part_mask", u_if.m_mask_o, 16'hC000);
    check_val("tp_part_last", u_if.m_last_o, 1'b1);
    idle(1'b1);

    // Backpressure: block held and input stalled for ten cycles, then released.
    for (int j = 0; j < 4; j++) step(1'b1, $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
    d5 = $urandom;
    for (int j = 0; j < 10; j++) begin
      step(1'b1, d5, 4'hF, 1'b0, 1'b0, 1'b0);
      check_val("tp_bp_ready", u_if.s_ready_o, 1'b0);
    end
    step(1'b1, d5, 4'hF, 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) step(1'b1, $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
    idle(1'b1);

    // Flush mid-block drops the word offered with it and clears the block count.
    step(1'b1, $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
    step(1'b1, $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
    step(1'b1, $urandom, 4'hF, 1'b0, 1'b1, 1'b1);
    check_val("tp_flush_cnt", blk_cnt_o, 32'd0);
    for (int j = 0; j < 4; j++) begin
      w[j] = $urandom;
      step(1'b1, w[j], 4'hF, 1'b0, 1'b1, 1'b0);
    end
    check_val("tp_flush_blk", u_if.m_block_o, {w[0], w[1], w[2], w[3]});
    check_val("tp_flush_mask", u_if.m_mask_o, 16'hFFFF);
    idle(1'b1);

    // Empty last word at the start of a block.
    step(1'b1, $urandom, 4'h0, 1'b1, 1'b1, 1'b0);
    check_val("tp_empty_blk", u_if.m_block_o, {16{PAD}});
    check_val("tp_empty_mask", u_if.m_mask_o, 16'h0000);
    check_val("tp_empty_last", u_if.m_last_o, 1'b1);
    idle(1'b1);

    // Illegal keep on a non-last word.
    step(1'b1, $urandom, 4'h7, 1'b0, 1'b1, 1'b0);
`ifdef PACKER_KEEP_CHECK_EN
    check_val("tp_err_set", err_o, 1'b1);
    step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    check_val("tp_err_flush", err_o, 1'b1);
`else
    check_val("tp_err_off", err_o, 1'b0);
`endif

    // Randomized traffic with stalls and occasional flushes.
    for (int n = 0; n < 3000; n++) begin
      bit l;
      logic [3:0] k;
      l = ($urandom_range(0, 4) == 0);
      k = l ? last_keeps[$urandom_range(0, 4)] : 4'($urandom);
      step($urandom_range(0, 9) < 7, $urandom, k, l,
           $urandom_range(0, 9) < 6, $urandom_range(0, 63) == 0);
    end
    repeat (2) idle(1'b1);

    // Asynchronous reset in the middle of a block.
    step(1'b1, $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
    step(1'b1, $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", u_if.m_valid_o, 1'b0);
    check_val("mid_rst_cnt", blk_cnt_o, 32'd0);
    check_val("mid_rst_err", err_o, 1'b0);
    model_clear();
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) step(1'b1, $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
